// File: rtl/lcd_hex_display.sv
// ---------------------------------------------------------------------------
// lcd_hex_display
//
// Drives an HD44780-class character LCD in 8-bit mode. After reset it runs
// the power-up delay and the init command sequence on its own, then keeps
// refreshing NUM_DIGITS hex digits taken from a packed input bus.
//
// Every byte goes out as a 3-cycle write: SETUP (RS/DB driven, E=0),
// PULSE (E=1), HOLD (E=0, RS/DB unchanged). RS and DB only ever change on
// the edge that enters SETUP.
//
// Ports:
//   clk_1ms     in   1 kHz clock, all state changes on its rising edge
//   reset       in   synchronous, active-high
//   blank       in   1 = every digit of the next frame shows as space
//   data        in   packed digits, leftmost in the top nibble
//   E           out  LCD enable strobe
//   RW          out  constant 0 (write only)
//   RS          out  0 = command, 1 = character
//   DB          out  LCD data bus
//   ready       out  set once init has completed
//   frame_done  out  one-cycle pulse after the last character of a frame
//
// Build option:
//   LCD_HEX_ZERO_SUPPRESS_EN - when defined, leading zero digits of each
//   frame are shown as space (the rightmost digit is always shown).
//
// FSM states:
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_POWERUP | quiet wait of POWERUP_MS cycles after reset
//   ST_INIT    | writing the four init commands (extra wait after clear)
//   ST_ADDR    | data/blank snapshotted; writing the DDRAM address command
//   ST_CHAR    | writing NUM_DIGITS characters from the snapshot
//   ST_IDLE    | frame_done pulse, then REFRESH_MS idle cycles
// ---------------------------------------------------------------------------
module lcd_hex_display #(
    parameter int         NUM_DIGITS = 4,
    parameter logic [6:0] START_ADDR = 7'h00,
    parameter int         POWERUP_MS = 20,
    parameter int         REFRESH_MS = 50
) (
    input  logic                    clk_1ms,
    input  logic                    reset,
    input  logic                    blank,
    input  logic [4*NUM_DIGITS-1:0] data,
    output logic                    E,
    output logic                    RW,
    output logic                    RS,
    output logic [7:0]              DB,
    output logic                    ready,
    output logic                    frame_done
);

    localparam int DW = $clog2(NUM_DIGITS + 1);

    // One shared down-counter covers the power-up wait, the post-clear wait
    // and the refresh idle time, so it is sized for the largest of them.
    localparam int CNT_MAX = (POWERUP_MS > REFRESH_MS)
                             ? ((POWERUP_MS > 2) ? POWERUP_MS : 2)
                             : ((REFRESH_MS > 2) ? REFRESH_MS : 2);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam int PWR_LOAD_I  = (POWERUP_MS > 0) ? POWERUP_MS - 1 : 0;
    localparam int IDLE_LOAD_I = (REFRESH_MS > 0) ? REFRESH_MS - 1 : 0;
    localparam logic [CW-1:0] PWR_LOAD  = PWR_LOAD_I[CW-1:0];
    localparam logic [CW-1:0] IDLE_LOAD = IDLE_LOAD_I[CW-1:0];
    // Clear needs 1.52 ms: HOLD of the clear command is stretched by 2.
    localparam logic [CW-1:0] CLR_WAIT  = CW'(2);
    localparam logic [DW-1:0] LAST_DIG  = DW'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_ADDR,
        ST_CHAR,
        ST_IDLE
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_t;

    state_t                  state_q, state_d;
    phase_t                  phase_q, phase_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              init_idx_q, init_idx_d;
    logic [DW-1:0]           dig_idx_q, dig_idx_d;
    logic [4*NUM_DIGITS-1:0] snap_data_q, snap_data_d;
    logic                    snap_blank_q, snap_blank_d;
    logic                    e_q, e_d;
    logic                    rs_q, rs_d;
    logic [7:0]              db_q, db_d;
    logic                    ready_q, ready_d;
    logic                    fd_q, fd_d;

    logic                    enter_addr;
    logic [DW-1:0]           next_dig;
    logic [3:0]              sel_nib;
    logic [7:0]              char_byte;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Character to be presented in the next SETUP: digit 0 when leaving
    // the address write, otherwise the digit after the current one.
    assign next_dig = (state_q == ST_ADDR) ? '0 : dig_idx_q + DW'(1);

    always_comb begin
        sel_nib = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (next_dig == DW'(k)) begin
                sel_nib = snap_data_q[4*(NUM_DIGITS-1-k) +: 4];
            end
        end
    end

`ifdef LCD_HEX_ZERO_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  sel_sup;

    // lead_zero[k]: digits 0..k of the snapshot are all zero.
    always_comb begin
        lead_zero    = '0;
        lead_zero[0] = (snap_data_q[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int k = 1; k < NUM_DIGITS; k++) begin
            lead_zero[k] = lead_zero[k-1]
                           && (snap_data_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
        end
    end

    // The rightmost digit is never suppressed, so the loop stops short of it.
    always_comb begin
        sel_sup = 1'b0;
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            if (next_dig == DW'(k)) begin
                sel_sup = lead_zero[k];
            end
        end
    end

    assign char_byte = (snap_blank_q || sel_sup) ? 8'h20 : nib_to_ascii(sel_nib);
`else
    assign char_byte = snap_blank_q ? 8'h20 : nib_to_ascii(sel_nib);
`endif

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        init_idx_d   = init_idx_q;
        dig_idx_d    = dig_idx_q;
        snap_data_d  = snap_data_q;
        snap_blank_d = snap_blank_q;
        e_d          = 1'b0;
        rs_d         = rs_q;
        db_d         = db_q;
        ready_d      = ready_q;
        fd_d         = 1'b0;
        enter_addr   = 1'b0;

        case (state_q)
            ST_POWERUP: begin
                if (cnt_q == '0) begin
                    state_d    = ST_INIT;
                    phase_d    = PH_SETUP;
                    init_idx_d = 2'd0;
                    rs_d       = 1'b0;
                    db_d       = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            ST_INIT, ST_ADDR, ST_CHAR: begin
                case (phase_q)
                    PH_SETUP: begin
                        phase_d = PH_PULSE;
                        e_d     = 1'b1;
                    end
                    PH_PULSE: begin
                        phase_d = PH_HOLD;
                        cnt_d   = (state_q == ST_INIT && init_idx_q == 2'd2)
                                  ? CLR_WAIT : '0;
                    end
                    PH_HOLD: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CW'(1);
                        end else begin
                            phase_d = PH_SETUP;
                            case (state_q)
                                ST_INIT: begin
                                    if (init_idx_q == 2'd3) begin
                                        enter_addr = 1'b1;
                                    end else begin
                                        init_idx_d = init_idx_q + 2'd1;
                                        rs_d       = 1'b0;
                                        db_d       = init_cmd(init_idx_q + 2'd1);
                                    end
                                end
                                ST_ADDR: begin
                                    state_d   = ST_CHAR;
                                    dig_idx_d = '0;
                                    rs_d      = 1'b1;
                                    db_d      = char_byte;
                                end
                                ST_CHAR: begin
                                    dig_idx_d = dig_idx_q + DW'(1);
                                    if (dig_idx_q == LAST_DIG) begin
                                        state_d = ST_IDLE;
                                        fd_d    = 1'b1;
                                        cnt_d   = IDLE_LOAD;
                                    end else begin
                                        rs_d = 1'b1;
                                        db_d = char_byte;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end

            ST_IDLE: begin
                if (cnt_q == '0) begin
                    enter_addr = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: state_d = ST_POWERUP;
        endcase

        // Frame start: the snapshot taken here is what the whole frame
        // shows, so mid-frame input changes cannot tear the display.
        if (enter_addr) begin
            state_d      = ST_ADDR;
            phase_d      = PH_SETUP;
            dig_idx_d    = '0;
            snap_data_d  = data;
            snap_blank_d = blank;
            ready_d      = 1'b1;
            rs_d         = 1'b0;
            db_d         = {1'b1, START_ADDR};
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (reset) begin
            state_q      <= ST_POWERUP;
            phase_q      <= PH_SETUP;
            cnt_q        <= PWR_LOAD;
            init_idx_q   <= 2'd0;
            dig_idx_q    <= '0;
            snap_data_q  <= '0;
            snap_blank_q <= 1'b0;
            e_q          <= 1'b0;
            rs_q         <= 1'b0;
            db_q         <= 8'h00;
            ready_q      <= 1'b0;
            fd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            init_idx_q   <= init_idx_d;
            dig_idx_q    <= dig_idx_d;
            snap_data_q  <= snap_data_d;
            snap_blank_q <= snap_blank_d;
            e_q          <= e_d;
            rs_q         <= rs_d;
            db_q         <= db_d;
            ready_q      <= ready_d;
            fd_q         <= fd_d;
        end
    end

    assign E          = e_q;
    assign RW         = 1'b0;
    assign RS         = rs_q;
    assign DB         = db_q;
    assign ready      = ready_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_hex_display.sv
// ---------------------------------------------------------------------------
// tb_lcd_hex_display
//
// Directed bench for lcd_hex_display (NUM_DIGITS=4, START_ADDR=0,
// POWERUP_MS=20, REFRESH_MS=5). The stimulus process pushes every expected
// E-pulse (RS, DB and the cycle distance from the previous pulse, or from
// the last reset edge for the first one) into a queue; an independent
// monitor pops and compares on each rising E, and also checks HOLD
// stability, ready rise time and frame_done placement.
// ---------------------------------------------------------------------------
module tb_lcd_hex_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        blank;
    logic [15:0] data;
    logic        E, RW, RS, ready, frame_done;
    logic [7:0]  DB;

    lcd_hex_display #(
        .NUM_DIGITS(4),
        .START_ADDR(7'h00),
        .POWERUP_MS(20),
        .REFRESH_MS(5)
    ) dut (
        .clk_1ms   (clk),
        .reset     (reset),
        .blank     (blank),
        .data      (data),
        .E         (E),
        .RW        (RW),
        .RS        (RS),
        .DB        (DB),
        .ready     (ready),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic rst_smp = 1'b1;
    int   ref_cyc = 0;
    int   last_pulse = -1;
    logic e_prev = 1'b0, rdy_prev = 1'b0, fd_prev = 1'b0;
    logic [8:0] held = '0;
    int   rw_bad = 0;
    int   fd_count = 0;
    int   frames = 0;

    always @(posedge clk) begin
        cyc++;
        rst_smp = reset;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   gap;
        if (RW !== 1'b0) rw_bad++;
        if (rst_smp) begin
            ref_cyc    = cyc;
            last_pulse = -1;
            e_prev     = 1'b0;
            rdy_prev   = 1'b0;
            fd_prev    = 1'b0;
        end else begin
            if (E === 1'b1 && !e_prev) begin
                gap = (last_pulse < 0) ? cyc - ref_cyc : cyc - last_pulse;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got RS=%0b DB=%02h, required no write (cycle %0d)",
                             RS, DB, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("write_rs", RS, e.rs);
                    check("write_db", DB, e.db);
                    check("write_gap", gap, e.gap);
                end
                last_pulse = cyc;
                held = {RS, DB};
            end
            if (E === 1'b0 && e_prev) check("hold_stable", {RS, DB}, held);
            if (ready === 1'b1 && !rdy_prev) check("ready_rise", cyc - ref_cyc, 34);
            if (frame_done === 1'b1) begin
                fd_count++;
                check("frame_done_time", cyc - last_pulse, 2);
                check("frame_done_width", fd_prev, 0);
            end
            e_prev   = E;
            rdy_prev = ready;
            fd_prev  = frame_done;
        end
    end

    task automatic push(input logic rs, input logic [7:0] db, input int gap);
        exp_t e;
        e.rs  = rs;
        e.db  = db;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(1'b0, 8'h38, 21);
        push(1'b0, 8'h0C, 3);
        push(1'b0, 8'h01, 3);
        push(1'b0, 8'h06, 5);
    endtask

    task automatic push_frame(input int gap0, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        push(1'b0, 8'h80, gap0);
        push(1'b1, c0, 3);
        push(1'b1, c1, 3);
        push(1'b1, c2, 3);
        push(1'b1, c3, 3);
    endtask

    task automatic wait_size(input string name, input int k);
        int n = 0;
        while (exp_q.size() > k && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > k) begin
            check(name, exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    task automatic wait_drain(input string name);
        wait_size(name, 0);
        frames++;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        blank = 1'b0;
        data  = 16'hA5C3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_E", E, 0);
        check("rst_RW", RW, 0);
        check("rst_RS", RS, 0);
        check("rst_DB", DB, 8'h00);
        check("rst_ready", ready, 0);
        check("rst_frame_done", frame_done, 0);

        push_init();
        push_frame(3, 8'h41, 8'h35, 8'h43, 8'h33);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_drain("init_frame1");

        push_frame(8, 8'h41, 8'h35, 8'h43, 8'h33);
        wait_drain("frame2");

        // Blank snapshotted at frame start; clearing it mid-frame must not matter.
        blank = 1'b1;
        push_frame(8, 8'h20, 8'h20, 8'h20, 8'h20);
        wait_size("blank_mid", 2);
        blank = 1'b0;
        wait_drain("frame_blank");

        push_frame(8, 8'h41, 8'h35, 8'h43, 8'h33);
        wait_drain("frame_unblank");

        // Data changed during the third character write.
        data = 16'h1234;
        push_frame(8, 8'h31, 8'h32, 8'h33, 8'h34);
        wait_size("data_mid", 1);
        data = 16'hFFFF;
        wait_drain("frame_1234");

        push_frame(8, 8'h46, 8'h46, 8'h46, 8'h46);
        wait_drain("frame_ffff");

        data = 16'h0070;
`ifdef LCD_HEX_ZERO_SUPPRESS_EN
        push_frame(8, 8'h20, 8'h20, 8'h37, 8'h30);
`else
        push_frame(8, 8'h30, 8'h30, 8'h37, 8'h30);
`endif
        wait_drain("frame_0070");

        data = 16'h0000;
`ifdef LCD_HEX_ZERO_SUPPRESS_EN
        push_frame(8, 8'h20, 8'h20, 8'h20, 8'h30);
`else
        push_frame(8, 8'h30, 8'h30, 8'h30, 8'h30);
`endif
        wait_drain("frame_0000");

        // Reset sampled on the edge that ends a PULSE cycle.
        data = 16'hA5C3;
        push(1'b0, 8'h80, 8);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (E !== 1'b1 && n < 100);
        check("e_before_reset", E, 1);
        #1 reset = 1'b1;
        push_init();
        push_frame(3, 8'h41, 8'h35, 8'h43, 8'h33);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_E", E, 0);
        check("midrst_ready", ready, 0);
        wait_drain("reinit_frame");

        repeat (5) @(posedge clk);
        check("rw_always_zero", rw_bad, 0);
        check("frame_done_count", fd_count, frames);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_hex_display.md
# lcd_hex_display

Parametrised HD44780-class character LCD driver that shows `NUM_DIGITS` hex digits from a packed input bus.

- Performs the full power-up and init sequence itself, then refreshes the digits in a continuous frame loop.
- Converts each nibble to ASCII, with optional whole-display blanking and compile-time leading-zero suppression.
- Runs on the 1 ms tick clock and drives the panel's E/RW/RS/DB pins directly.
- Replaces the fixed 4-digit controller/datapath pair; has no external controller.

## Interface

Parameters:
- `NUM_DIGITS`, default 4: digits shown, legal range 1..16.
- `START_ADDR`, default 7'h00: DDRAM address of the leftmost digit; 7'h40 selects line 2.
- `POWERUP_MS`, default 20: idle ticks after reset before the first command.
- `REFRESH_MS`, default 50: idle ticks between frames; 0 means back-to-back frames.

Ports. One clock; reset is synchronous and active-high.
- `clk_1ms`  in  1: 1 kHz clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `blank`  in  1: 1 shows all digits as space (0x20).
- `data`  in  4*NUM_DIGITS: packed digits; `data[4*NUM_DIGITS-1 -: 4]` is the leftmost digit.
- `E`  out  1: LCD enable strobe.
- `RW`  out  1: tied 0 (write only).
- `RS`  out  1: 0 for command, 1 for character data.
- `DB`  out  8: LCD data bus.
- `ready`  out  1: high once the init sequence has completed.
- `frame_done`  out  1: one-cycle pulse after the last character write of each frame.

## Operation

- States: POWERUP, INIT, ADDR, CHAR, IDLE. A byte-write sub-sequencer inside the init, address and character phases uses phases SETUP, PULSE, HOLD.
- POWERUP:
  - Counts `POWERUP_MS` cycles with all outputs at their reset values.
  - Then goes to INIT.
- INIT writes these commands (RS=0) in order:
  - 0x38: 8-bit, 2-line, 5x8.
  - 0x0C: display on, cursor off.
  - 0x01: clear.
  - 0x06: increment, no shift.
  - After 0x01 the block waits 2 extra cycles (clear takes 1.52 ms).
- ADDR:
  - Snapshots `data` and `blank` into internal registers on the cycle it is entered.
  - Raises `ready` on the first entry.
  - Writes command `{1'b1, START_ADDR}` with RS=0.
- CHAR:
  - Writes `NUM_DIGITS` characters, RS=1, from the snapshot, leftmost digit first.
  - Nibble mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
  - When the snapshot `blank` is set, every character is 0x20.
- IDLE:
  - `frame_done` pulses on entry.
  - Waits `REFRESH_MS` cycles, then returns to ADDR. Init is not repeated.
- Digit index counter width: `$clog2(NUM_DIGITS+1)`. It wraps to 0 at each ADDR entry.
- Changes on `data` or `blank` during a frame have no effect until the next ADDR entry. No tearing.

## Timing

- Byte write takes 3 cycles:
  - SETUP: RS and DB driven, E=0.
  - PULSE: E=1, RS and DB stable.
  - HOLD: E=0, RS and DB still stable.
- DB and RS change only in SETUP.
- First E high is at cycle `POWERUP_MS`+1 after the reset-release edge.
- Init length: `POWERUP_MS` + 4×3 + 2 cycles.
- Frame length: 3×(`NUM_DIGITS`+1) cycles of writes plus `REFRESH_MS` idle cycles.
- With `REFRESH_MS`=0:
  - IDLE lasts exactly 1 cycle.
  - `frame_done` still pulses.
- Reset values: E=0, RW=0, RS=0, DB=0x00, ready=0, frame_done=0. Snapshot registers are cleared.
- Reset asserted mid-operation, including during PULSE:
  - E=0 and ready=0 on the next edge.
  - The FSM returns to POWERUP and the full init is replayed.
  - No partial byte completes.
- `RW` is constant 0 in every cycle.

## Configuration

- Macro: `LCD_HEX_ZERO_SUPPRESS_EN`.
- Defined:
  - Leading zero digits in the snapshot are sent as 0x20.
  - Suppression stops at the first nonzero digit.
  - The rightmost digit is always shown, even if zero.
  - `blank` still overrides everything.
- Undefined:
  - All digits are shown, zeros included.
  - No extra logic is compiled in.

## Test plan

All scenarios use `NUM_DIGITS`=4, `START_ADDR`=0, `POWERUP_MS`=20, `REFRESH_MS`=5.

1. Release reset, then count cycles → E low for 20 cycles; E pulses carry DB 0x38, 0x0C, 0x01, 0x06 with RS=0; after 0x01 there are 2 extra idle cycles before the next SETUP; `ready` rises at ADDR entry.
2. data=16'hA5C3, blank=0 → E pulses 0x80 (RS=0), then 0x41, 0x35, 0x43, 0x33 (RS=1); `frame_done` pulses 1 cycle; 5 idle cycles; the frame repeats.
3. blank=1 before ADDR entry → frame writes 0x80, then 0x20 ×4; toggling blank mid-frame leaves the current frame unchanged.
4. data changes 16'h1234 → 16'hFFFF during the third character write → current frame finishes with 0x33, 0x34; the next frame writes 0x46 ×4.
5. Assert reset for 1 cycle while E=1 → E=0 and ready=0 next edge; exactly 20 quiet cycles; the full init sequence replays.
6. With `LCD_HEX_ZERO_SUPPRESS_EN`:
   - data=16'h0070 → characters 0x20, 0x20, 0x37, 0x30.
   - data=16'h0000 → characters 0x20, 0x20, 0x20, 0x30.
   - Without the macro, 16'h0070 → 0x30, 0x30, 0x37, 0x30.
